// File: rtl/lpc_record_fifo.sv
// lpc_record_fifo
// Takes one record for each completed LPC cycle reported by the decoder. Each record
// holds the cycle type/dir, the I/O address and the data byte. Records are buffered in a
// circular FIFO. A byte serializer then sends each record MSB-first as four bytes on a
// valid/ready stream toward the UART transmitter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no record in flight; pops the FIFO as soon as it is non-empty
// ST_B0    | presenting record[31:24] (cyctype/dir, drop flag)
// ST_B1    | presenting record[23:16] (address high byte)
// ST_B2    | presenting record[15:8]  (address low byte)
// ST_B3    | presenting record[7:0]   (data); an accept chains straight into the next record

module lpc_record_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    in_cyctype_dir,
    input  logic [31:0]   in_addr,
    input  logic [7:0]    in_data,
    input  logic          in_latch,
    output logic [7:0]    out_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   fifo_count,
    output logic [7:0]    drop_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_B0,
        ST_B1,
        ST_B2,
        ST_B3
    } state_t;

    state_t         state;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           latch_q;
    logic           drop_pending;
    logic [31:0]    rec;

    logic           capture;
    logic           fifo_full;
    logic           fifo_nonempty;
    logic           wr_en;
    logic           pop;
    logic [31:0]    rec_new;
    logic [31:0]    rd_rec;
    logic           unused_addr_hi;

    // The upper address bits are not part of the record.
    assign unused_addr_hi = ^in_addr[31:16];

    assign capture       = in_latch & ~latch_q;
    assign fifo_full     = (fifo_count == (AW+1)'(DEPTH));
    assign fifo_nonempty = (fifo_count != '0);
    assign wr_en         = capture & ~fifo_full;
    // The serializer takes a record only when one was stored before this edge. A
    // capture on the same edge is not visible yet, and a pop on the same edge does
    // not make room for that capture.
    assign pop           = fifo_nonempty &
                           ((state == ST_IDLE) | ((state == ST_B3) & out_ready));
    assign rec_new       = {in_cyctype_dir, 3'b000, drop_pending, in_addr[15:0], in_data};
    assign rd_rec        = mem[rd_ptr];

    // Record storage; it needs no reset because the pointers and the count define
    // which entries are valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= rec_new;
        end
    end

    // Latch edge detect, pointers, occupancy and drop accounting.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q      <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            drop_count   <= '0;
            drop_pending <= 1'b0;
        end else begin
            latch_q <= in_latch;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (capture && fifo_full) begin
                drop_pending <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end else if (wr_en) begin
                drop_pending <= 1'b0;
            end
        end
    end

    // Byte serializer with registered stream outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rec       <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        rec       <= rd_rec;
                        out_byte  <= rd_rec[31:24];
                        out_valid <= 1'b1;
                        state     <= ST_B0;
                    end
                end
                ST_B0: begin
                    if (out_ready) begin
                        out_byte <= rec[23:16];
                        state    <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (out_ready) begin
                        out_byte <= rec[15:8];
                        state    <= ST_B2;
                    end
                end
                ST_B2: begin
                    if (out_ready) begin
                        out_byte <= rec[7:0];
                        state    <= ST_B3;
                    end
                end
                ST_B3: begin
                    if (out_ready) begin
                        if (pop) begin
                            rec      <= rd_rec;
                            out_byte <= rd_rec[31:24];
                            state    <= ST_B0;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_record_fifo.sv
// Directed bench for lpc_record_fifo. The expected bytes are worked out by hand from the
// record layout {cyctype_dir, 3'b000, dflag, addr[15:0], data}.

module tb_lpc_record_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    in_cyctype_dir = '0;
    logic [31:0]   in_addr = '0;
    logic [7:0]    in_data = '0;
    logic          in_latch = 1'b0;
    logic          out_ready = 1'b1;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic [AW:0]   fifo_count;
    logic [7:0]    drop_count;

    int compared   = 0;
    int mismatched = 0;

    lpc_record_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_cyctype_dir (in_cyctype_dir),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_latch       (in_latch),
        .out_byte       (out_byte),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .fifo_count     (fifo_count),
        .drop_count     (drop_count)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rec(input logic [3:0] t, input logic [31:0] a, input logic [7:0] d);
        in_cyctype_dir = t;
        in_addr        = a;
        in_data        = d;
    endtask

    logic [7:0] t3_exp [12] = '{8'h10, 8'h12, 8'h34, 8'h56,
                                8'h30, 8'hAB, 8'hCD, 8'hEF,
                                8'hF0, 8'h00, 8'h01, 8'h02};
    logic [7:0] t5_exp [4]  = '{8'h70, 8'h00, 8'hAA, 8'h55};
    int         n;
    logic [7:0] last;

    initial begin
        // Reset state
        reset = 1'b1;
        step(); step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_drop", drop_count, 0);
        reset = 1'b0;
        step();

        // T1: single record, consumer always ready
        set_rec(4'h2, 32'h0000_0080, 8'h3C);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        chk("t1_count_after_capture", fifo_count, 1);
        chk("t1_not_yet_valid", out_valid, 0);
        step();
        chk("t1_count_after_pop", fifo_count, 0);
        chk("t1_valid_b0", out_valid, 1);
        chk("t1_b0", out_byte, 8'h20);
        step();
        chk("t1_b1", out_byte, 8'h00);
        step();
        chk("t1_b2", out_byte, 8'h80);
        step();
        chk("t1_b3", out_byte, 8'h3C);
        step();
        chk("t1_idle", out_valid, 0);

        // T2: backpressure on byte 2
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t2_b0", out_byte, 8'h20);
        step();
        chk("t2_b1", out_byte, 8'h00);
        step();
        chk("t2_b2", out_byte, 8'h80);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t2_hold_byte_%0d", i), out_byte, 8'h80);
            chk($sformatf("t2_hold_valid_%0d", i), out_valid, 1);
        end
        out_ready = 1'b1;
        step();
        chk("t2_b3", out_byte, 8'h3C);
        step();
        chk("t2_idle", out_valid, 0);

        // T3: three records back-to-back; the upper address bits of record 1 are ignored
        for (int i = 0; i < 14; i++) begin
            if (i == 0) set_rec(4'h1, 32'h0000_1234, 8'h56);
            if (i == 2) set_rec(4'h3, 32'hFFFF_ABCD, 8'hEF);
            if (i == 4) set_rec(4'hF, 32'h0000_0001, 8'h02);
            in_latch = (i == 0 || i == 2 || i == 4);
            step();
            if (i >= 1 && i <= 12) begin
                chk($sformatf("t3_valid_%0d", i - 1), out_valid, 1);
                chk($sformatf("t3_byte_%0d", i - 1), out_byte, t3_exp[i-1]);
            end else if (i == 13) begin
                chk("t3_idle", out_valid, 0);
            end
        end
        in_latch = 1'b0;
        step();

        // T4: overflow. The first capture is held in the serializer, the next 16 fill
        // the FIFO and the last 2 are dropped.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_rec(4'h5, 32'(i), 8'(i));
            in_latch = 1'b1;
            step();
            in_latch = 1'b0;
            step();
            if (i == DEPTH) begin
                chk("t4_count_full", fifo_count, DEPTH);
                chk("t4_no_drop_yet", drop_count, 0);
            end
        end
        chk("t4_count", fifo_count, DEPTH);
        chk("t4_drop", drop_count, 2);
        chk("t4_held_valid", out_valid, 1);
        chk("t4_held_byte", out_byte, 8'h50);
        out_ready = 1'b1;
        n = 0;
        last = '0;
        for (int g = 0; g < 300 && n < 4 * (DEPTH + 1); g++) begin
            if (out_valid) begin
                n++;
                last = out_byte;
            end
            step();
        end
        chk("t4_drained_bytes", n, 4 * (DEPTH + 1));
        chk("t4_last_kept_data", last, 8'h10);
        chk("t4_drained_idle", out_valid, 0);
        chk("t4_drained_count", fifo_count, 0);
        chk("t4_drop_kept", drop_count, 2);
        set_rec(4'h6, 32'h0000_0042, 8'h99);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t4_dflag_set", out_byte, 8'h61);
        step(); step(); step();
        chk("t4_x_b3", out_byte, 8'h99);
        step();
        chk("t4_x_idle", out_valid, 0);
        set_rec(4'h6, 32'h0000_0043, 8'h77);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t4_dflag_clear", out_byte, 8'h60);
        step(); step(); step(); step();
        chk("t4_y_idle", out_valid, 0);

        // T5: latch high across reset release is not captured
        in_latch = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("t5_no_capture_count", fifo_count, 0);
        chk("t5_no_capture_valid", out_valid, 0);
        chk("t5_drop_reset", drop_count, 0);
        in_latch = 1'b0;
        step();
        set_rec(4'h7, 32'h0000_00AA, 8'h55);
        in_latch = 1'b1;
        step();
        chk("t5_one_capture", fifo_count, 1);
        in_latch = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t5_byte_%0d", k), out_byte, t5_exp[k]);
            step();
        end
        chk("t5_single_idle", out_valid, 0);
        chk("t5_single_count", fifo_count, 0);

        // T6: reset after byte 1 accepted, with a second record queued
        set_rec(4'h8, 32'h0000_1357, 8'h9A);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t6_b0", out_byte, 8'h80);
        set_rec(4'h8, 32'h0000_2468, 8'hBC);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t6_b2_shown", out_byte, 8'h57);
        chk("t6_queued", fifo_count, 1);
        reset = 1'b1;
        step();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_drop", drop_count, 0);
        reset = 1'b0;
        step(); step(); step();
        chk("t6_no_partial", out_valid, 0);
        set_rec(4'h9, 32'h0000_0BEE, 8'h0D);
        in_latch = 1'b1;
        step();
        in_latch = 1'b0;
        step();
        chk("t6_c_valid", out_valid, 1);
        chk("t6_c_b0", out_byte, 8'h90);
        step();
        chk("t6_c_b1", out_byte, 8'h0B);
        step();
        chk("t6_c_b2", out_byte, 8'hEE);
        step();
        chk("t6_c_b3", out_byte, 8'h0D);
        step();
        chk("t6_c_idle", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
